// File: rtl/pla_scan_pkg.sv
// Shared types and helpers for the multiplexed digit scanner.
package pla_scan_pkg;

    localparam int CODE_W     = 4;
    localparam int MAX_DIGITS = 32;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_t;

    // One-hot mask for a digit index; callers keep the low NUM_DIGITS bits.
    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned index);
        return MAX_DIGITS'(1) << index;
    endfunction

endpackage

// File: rtl/pla_slot_timer.sv
// Slot counter for the digit scanner: counts 0..PRESCALE-1 and flags the
// blank phase, the last blank cycle and the last cycle of the slot.
module pla_slot_timer #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    output logic in_blank,
    output logic blank_end,
    output logic slot_end
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] count;

    // Free-running slot counter that wraps after the last cycle of a slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (slot_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign in_blank  = (count < CNT_W'(BLANK_CYCLES));
    assign blank_end = (count == CNT_W'(BLANK_CYCLES - 1));
    assign slot_end  = (count == CNT_W'(PRESCALE - 1));

endmodule

// File: rtl/pla_digit_scanner.sv
// Time-multiplexed digit scanner feeding a 7-segment decoder. New digit sets
// are buffered in a pending register and swapped into the displayed shadow
// register only at frame boundaries, so a frame never mixes old and new data.
module pla_digit_scanner
    import pla_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CODE_W*NUM_DIGITS-1:0] digits_in,
    input  logic                         load_valid,
    output logic                         load_ready,
    output logic [CODE_W-1:0]            code_out,
    output logic [NUM_DIGITS-1:0]        dig_en,
    output logic                         frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SET_W = CODE_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                  in_blank;
    logic                  blank_end;
    logic                  slot_end;
    scan_state_t           state;
    logic [IDX_W-1:0]      index;
    logic [IDX_W-1:0]      next_index;
    logic [SET_W-1:0]      shadow;
    logic [SET_W-1:0]      pending;
    logic                  pending_full;
    logic                  frame_end;
    logic                  accept;
    logic [MAX_DIGITS-1:0] en_mask;

    pla_slot_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .in_blank  (in_blank),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    assign frame_end  = slot_end && (index == LAST_IDX);
    assign next_index = (index == LAST_IDX) ? '0 : index + 1'b1;
    assign accept     = load_valid && !pending_full;
    assign en_mask    = onehot(32'(index));
    assign load_ready = ~pending_full;
    assign frame_done = frame_end;

    // Handshake buffer: accept into pending, hand over to shadow at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else if (frame_end && pending_full) begin
            shadow       <= pending;
            pending_full <= 1'b0;
        end else if (accept) begin
            pending      <= digits_in;
            pending_full <= 1'b1;
        end
    end

    // Blank/show sequencer with registered enable and code outputs; the code
    // for a new slot comes from pending when the shadow is swapped that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BLANK;
            index    <= '0;
            dig_en   <= '0;
            code_out <= '0;
        end else begin
            case (state)
                BLANK: begin
                    if (in_blank && blank_end) begin
                        state  <= SHOW;
                        dig_en <= en_mask[NUM_DIGITS-1:0];
                    end
                end
                SHOW: begin
                    if (slot_end) begin
                        state  <= BLANK;
                        dig_en <= '0;
                        index  <= next_index;
                        if (frame_end && pending_full) begin
                            code_out <= pending[CODE_W-1:0];
                        end else begin
                            code_out <= shadow[32'(next_index)*CODE_W +: CODE_W];
                        end
                    end
                end
                default: begin
                    state <= BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pla_digit_scanner.sv
// Self-checking bench for pla_digit_scanner with NUM_DIGITS=4, PRESCALE=8,
// BLANK_CYCLES=2. The reference tracks time since reset and derives slot,
// phase and digit arithmetically, plus a shadow/pending pair for loads.
module tb_pla_digit_scanner;

    localparam int N     = 4;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * P;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   digits_in;
    logic          load_valid;
    logic          load_ready;
    logic [3:0]    code_out;
    logic [N-1:0]  dig_en;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    int          t;
    logic [15:0] m_shadow;
    logic [15:0] m_pending;
    bit          m_full;

    pla_digit_scanner #(
        .NUM_DIGITS   (N),
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .code_out   (code_out),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, actual, expected, t);
        end
    endtask

    task automatic modelReset();
        t         = 0;
        m_shadow  = '0;
        m_pending = '0;
        m_full    = 1'b0;
    endtask

    task automatic checkAll();
        int slot;
        int pos;
        int dig;
        slot = t / P;
        pos  = t % P;
        dig  = slot % N;
        checkOutput("code_out",   32'(code_out),   32'((m_shadow >> (4 * dig)) & 16'hF));
        checkOutput("dig_en",     32'(dig_en),     (pos < B) ? 32'd0 : (32'd1 << dig));
        checkOutput("frame_done", 32'(frame_done), 32'((pos == P - 1) && (dig == N - 1)));
        checkOutput("load_ready", 32'(load_ready), 32'(!m_full));
        checkOutput("onehot",     32'($countones(dig_en) <= 1), 32'd1);
        assert ($countones(dig_en) <= 1)
        else $error("[TB] dig_en has more than one bit set: %b", dig_en);
    endtask

    task automatic modelStep();
        bit boundary;
        boundary = ((t % P) == P - 1) && (((t / P) % N) == N - 1);
        if (boundary && m_full) begin
            m_shadow = m_pending;
            m_full   = 1'b0;
        end else if (load_valid && !m_full) begin
            m_pending = digits_in;
            m_full    = 1'b1;
        end
        t++;
    endtask

    task automatic runCycle(input logic valid, input logic [15:0] data);
        @(negedge clk);
        checkAll();
        load_valid = valid;
        digits_in  = data;
        @(posedge clk);
        modelStep();
    endtask

    task automatic applyStimulus(input int cycles, input int pct, input bit rand_data, input logic [15:0] data);
        for (int i = 0; i < cycles; i++) begin
            runCycle(($urandom % 100) < pct, rand_data ? 16'($urandom) : data);
        end
    endtask

    task automatic idleUntil(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) begin
            runCycle(1'b0, 16'h0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        digits_in  = '0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAll();
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle scan after reset
        applyStimulus(2 * FRAME, 0, 1'b0, 16'h0);

        // Single load mid-frame
        idleUntil(5);
        runCycle(1'b1, 16'h9876);
        applyStimulus(2 * FRAME, 0, 1'b0, 16'h0);

        // Second load stalls behind the first
        idleUntil(3);
        runCycle(1'b1, 16'h1234);
        applyStimulus(4, 0, 1'b0, 16'h0);
        applyStimulus(FRAME + 4, 100, 1'b0, 16'h5555);
        applyStimulus(3 * FRAME, 0, 1'b0, 16'h0);

        // Load on the frame_done cycle
        idleUntil(FRAME - 1);
        runCycle(1'b1, 16'h4321);
        applyStimulus(2 * FRAME, 0, 1'b0, 16'h0);

        // Codes above 9 pass through
        runCycle(1'b1, 16'hFACB);
        applyStimulus(2 * FRAME + 2, 0, 1'b0, 16'h0);

        // Reset during SHOW of digit 2 with data pending
        idleUntil(1);
        runCycle(1'b1, 16'hABCD);
        idleUntil(2 * P + 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_dig_en",     32'(dig_en),     32'd0);
        checkOutput("rst_code_out",   32'(code_out),   32'd0);
        checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        modelReset();
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(2 * FRAME, 0, 1'b0, 16'h0);

        // Random traffic
        applyStimulus(600, 10, 1'b1, 16'h0);
        applyStimulus(200, 60, 1'b1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
